// File: rtl/arith_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks:
// FSM encodings, default widths and saturation limits.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } state_t;

    localparam int DEF_N    = 11;
    localparam int DEF_FRAC = 8;

    // Largest positive value representable in n-bit two's complement.
    function automatic int sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    // Most negative value representable in n-bit two's complement.
    function automatic int sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage

// File: rtl/round_sat.sv
// Rounds an unsigned 2N-bit magnitude product back to QN.FRAC and applies
// the sign with saturation. Purely combinational.
module round_sat
    import arith_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int FRAC = DEF_FRAC
) (
    input  logic [2*N-1:0] p,
    input  logic           sign,
    output logic [N-1:0]   result
);

    localparam int SW = 2 * N + 1;
    localparam int MW = 2 * N - FRAC + 1;

    localparam logic [SW-1:0] RND     = SW'(1) << (FRAC - 1);
    localparam logic [MW-1:0] POS_LIM = MW'(sat_max(N));
    localparam logic [MW-1:0] NEG_LIM = MW'(-sat_min(N));

    logic [SW-1:0] sum;
    logic [MW-1:0] m;
    logic [N-1:0]  mag;

    // Rounding is applied to the magnitude, so a half rounds away from zero
    // for both signs; the negative limit is one larger than the positive one.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        sum    = {1'b0, p} + RND;
        m      = MW'(sum >> FRAC);
        mag    = '0;
        result = '0;
        if (!sign) begin
            mag    = (m > POS_LIM) ? N'(POS_LIM) : m[N-1:0];
            result = mag;
        end else begin
            mag    = (m > NEG_LIM) ? N'(NEG_LIM) : m[N-1:0];
            result = N'(0) - mag;
        end
    end

endmodule

// File: rtl/seq_fixmul.sv
// Iterative signed fixed-point multiplier: N shift-add cycles on operand
// magnitudes, then one cycle of rounding/saturation back to N bits.
module seq_fixmul
    import arith_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] result
);

    localparam int             CW   = $clog2(N) + 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_sh;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  addend;
    logic            sign;
    logic            done_q;
    logic [N-1:0]    res_q;
    logic [N-1:0]    rs_out;
    logic [N-1:0]    a_abs;
    logic [N-1:0]    b_abs;

    // |-2^(N-1)| wraps to 2^(N-1), which is exactly right read as unsigned.
    assign a_abs  = a[N-1] ? (~a + N'(1)) : a;
    assign b_abs  = b[N-1] ? (~b + N'(1)) : b;
    assign addend = {{N{1'b0}}, a_mag} << cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every datapath register is in the synchronous reset, so a reset
    // mid-calculation leaves no stale accumulator or result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            a_mag  <= '0;
            b_sh   <= '0;
            sign   <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= a[N-1] ^ b[N-1];
                        a_mag <= a_abs;
                        b_sh  <= b_abs;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (b_sh[0]) acc <= acc + addend;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                end
                NORM: begin
                    res_q  <= rs_out;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    round_sat #(
        .N    (N),
        .FRAC (FRAC)
    ) u_round_sat (
        .p      (acc),
        .sign   (sign),
        .result (rs_out)
    );

    // busy stays high through the done cycle, when the FSM is already idle.
    always_comb begin
        busy   = (state != IDLE) || done_q;
        done   = done_q;
        result = res_q;
    end

endmodule

// File: tb/tb_seq_fixmul.sv
// Directed bench for seq_fixmul: expected results are queued at start and
// popped when done pulses; handshake, latency and reset behaviour checked.
module tb_seq_fixmul;

    localparam int N    = 11;
    localparam int FRAC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           op_edges;
    int           op_busy;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] last_exp;

    always #5 clk = ~clk;

    seq_fixmul #(.N(N), .FRAC(FRAC)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, round half away from zero on magnitude, saturate.
    function automatic logic [N-1:0] model(input int x, input int y);
        longint p, mag, m, r;
        p   = longint'(x) * longint'(y);
        mag = (p < 0) ? -p : p;
        m   = (mag + (longint'(1) << (FRAC - 1))) >> FRAC;
        if (p >= 0) r = (m > 1023) ? 1023 : m;
        else        r = -((m > 1024) ? 1024 : m);
        return N'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        op_edges++;
        if (busy) op_busy++;
    endtask

    task automatic launch(input int av, input int bv, input logic [N-1:0] ex);
        start = 1'b1;
        a     = N'(av);
        b     = N'(bv);
        exp_q.push_back(ex);
        tick();
        start    = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        op_edges = 0;
        op_busy  = busy ? 1 : 0;
    endtask

    task automatic finish_op(input string tag);
        while (!done && op_edges < 40) step();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(op_edges), 32'(N + 1));
        check({tag, " busy cycles"}, 32'(op_busy), 32'(N + 2));
        check({tag, " busy in done cycle"}, 32'(busy), 32'd1);
        check({tag, " scoreboard has entry"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check({tag, " result"}, 32'(result), 32'(last_exp));
        end
    endtask

    task automatic idle_check(input string tag);
        tick();
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " done low"}, 32'(done), 32'd0);
        check({tag, " result held"}, 32'(result), 32'(last_exp));
    endtask

    task automatic run_case(input int av, input int bv, input logic [N-1:0] ex, input string tag);
        launch(av, bv, ex);
        finish_op(tag);
        idle_check(tag);
    endtask

    initial begin
        int dones;
        int ra;
        int rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        rst = 1'b0;
        tick();

        run_case(256, 384, 11'd384, "basic");
        run_case(-256, 384, 11'h680, "neg x pos");
        run_case(-256, -384, 11'd384, "neg x neg");
        run_case(0, -1024, 11'd0, "zero x neg");
        run_case(1, 128, 11'd1, "round half up");
        run_case(-1, 128, 11'h7FF, "round half neg");
        run_case(1, 127, 11'd0, "round below half");
        run_case(1023, 1023, 11'h3FF, "sat pos");
        run_case(-1024, 1023, 11'h400, "sat neg");
        run_case(-1024, -1024, 11'h3FF, "sat min x min");

        // Start pulse five cycles into CALC must be ignored.
        launch(256, 384, 11'd384);
        repeat (4) step();
        start = 1'b1;
        a     = N'(-1024);
        b     = N'(-1024);
        step();
        start = 1'b0;
        finish_op("start in calc");
        idle_check("start in calc");
        dones = 0;
        repeat (16) begin
            tick();
            if (done) dones++;
        end
        check("start in calc no extra done", 32'(dones), 32'd0);

        // Start sampled while in NORM is dropped.
        launch(-256, 384, 11'h680);
        while (op_edges < N) step();
        start = 1'b1;
        a     = N'(1023);
        b     = N'(1023);
        step();
        start = 1'b0;
        finish_op("start in norm");
        idle_check("start in norm");

        // Start in the done cycle is accepted back-to-back.
        launch(-256, -384, 11'd384);
        finish_op("b2b first");
        launch(1, 128, 11'd1);
        finish_op("b2b second");
        idle_check("b2b second");

        // Reset during CALC aborts the operation.
        launch(1023, 1023, 11'h3FF);
        repeat (3) step();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset result", 32'(result), 32'd0);
        dones = 0;
        repeat (20) begin
            tick();
            if (done) dones++;
        end
        check("mid reset no done", 32'(dones), 32'd0);
        run_case(-1024, -1024, 11'h3FF, "after reset");

        repeat (4) begin
            ra = int'($signed(N'($urandom)));
            rb = int'($signed(N'($urandom)));
            run_case(ra, rb, model(ra, rb), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_fixmul.md
# seq_fixmul

Iterative signed fixed-point multiplier for the arithmetic-operations datapath. It accepts two N-bit two's-complement operands on a start pulse and computes their product over N shift-add cycles. It then rounds and saturates the product back to N bits. Its `result`/`done` pair is the upstream producer for the N-bit `delay_mod` register stage, which aligns it with other datapath branches.

## Interface
- `N`, default 11: operand and result width, two's complement.
- `FRAC`, default 8: fractional bits of operands and result. Format is Q(N-FRAC).FRAC, and 1.0 = 256. Legal range is 1 ≤ FRAC ≤ N-1.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `a`  in  N: signed multiplicand. Captured on an accepted start.
- `b`  in  N: signed multiplier. Captured on an accepted start.
- `busy`  out  1: high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1: single-cycle pulse. `result` is valid in this cycle.
- `result`  out  N signed: rounded, saturated product. Holds its value until the next `done`.

## Operation
- **Reset.** `rst`=1 at an edge forces the following, regardless of state (including mid-CALC):
  - state = IDLE
  - `busy`=0, `done`=0, `result`=0
  - internal accumulator and counter cleared
- **IDLE**
  - When `start`=1:
    - latch sign = a[N-1]^b[N-1]
    - latch |a| and |b| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) fits)
    - clear the 2N-bit accumulator P and the counter
    - go to CALC
  - When `start`=0: stay in IDLE.
- **CALC**, exactly N cycles:
  - If the current LSB of the |b| shift register is 1, P += |a| << count.
  - Shift |b| right by one and increment the counter.
  - After the N-th iteration, go to NORM.
- **NORM**, 1 cycle:
  - M = (P + 2^(FRAC-1)) >> FRAC. This rounds half away from zero because it operates on the magnitude.
  - If sign=0: result = min(M, 2^(N-1)-1).
  - If sign=1: result = -min(M, 2^(N-1)). A zero magnitude gives 0, never negative zero.
  - Register `result`, assert `done` for 1 cycle, go to IDLE.
- **Start while busy.** `start` is ignored in CALC and NORM. It is not queued.
- **Start in the done cycle.** A `start` in the cycle where `done`=1 is accepted, since the FSM is already in IDLE. Back-to-back throughput is one result per N+2 cycles.
- **Width rules.**
  - P is 2N bits unsigned.
  - M needs 2N-FRAC+1 bits before saturation.
  - No intermediate truncation occurs before the saturation step.

## Timing
- Define edge 0 as the edge where `start`=1 is sampled in IDLE.
- `busy`=1 after edges 0 through N+1.
- `done`=1 and the new `result` appear after edge N+1. Latency is N+2 cycles from start to done-cycle (13 for N=11).
- `busy` and `done` are both 1 in the done cycle. `busy` falls together with `done` after edge N+2.
- A new start sampled at edge N+1 is ignored, because the FSM is still in NORM. A start at edge N+2 (the `done`-high cycle) is accepted.
- `rst` has priority over `start` in the same cycle.
- Inputs `a` and `b` are don't-care outside the accepting edge.

## Structure
- **Shared package `arith_pkg`**:
  - state encodings: IDLE=2'd0, CALC=2'd1, NORM=2'd2
  - default N=11 and FRAC=8
  - saturation limit functions for MAX = 2^(N-1)-1 and MIN = -2^(N-1)
- **Sub-module `round_sat`**, purely combinational: takes (P, sign) and produces the N-bit result. It is reused by future fixed-point blocks.
- **FSM, counter and shift-add datapath** live in `seq_fixmul`.

## Test plan
- **Basic multiply.** Reset for 2 cycles, then start with a=256 (1.0) and b=384 (1.5). Expect `done` 13 cycles later with result=384. `busy` is high for exactly 13 cycles.
- **Signs.**
  - a=-256, b=384: result=-384 (11'h680).
  - a=-256, b=-384: result=384.
  - a=0, b=-1024: result=0.
- **Rounding.**
  - a=1, b=128: result=1 (half rounds up).
  - a=-1, b=128: result=-1.
  - a=1, b=127: result=0.
- **Saturation.**
  - a=1023, b=1023: result=1023 (11'h3FF).
  - a=-1024, b=1023: result=-1024 (11'h400).
  - a=-1024, b=-1024: result=1023.
- **Handshake.**
  - Pulse start again 5 cycles into an operation with different operands. It is ignored, and the first result is unaffected.
  - Start asserted in the done cycle is accepted, and the next done comes 13 cycles later.
- **Reset mid-operation.** Assert `rst` for one cycle during CALC. On the next cycle `busy`=0, `done`=0, `result`=0, and no `done` pulse follows. A fresh start afterwards computes correctly.
